rtc_burst_seq: RTL and testbench
================================

# rtc_burst_seq

Parametrised burst sequencer for the multiplexed address/data parallel bus of the RTC. One `start` pulse runs a whole burst: write mode transfers `N_REGS` registers followed by the commit command, read mode issues the latch command followed by `N_REGS` reads. Sits between the time/date/timer register file and the RTC pins. It drives `a_d`, `cs_n`, `rd_n`, `wr_n` and the AD bus directly with programmable phase timing, and addresses the register file by index rather than by one-hot select lines.

## Interface
- `N_REGS`, 9: registers per burst (1..32).
- `ADDR_LIST`, {8'h21,8'h22,8'h23,8'h24,8'h25,8'h26,8'h41,8'h42,8'h43}: packed RTC addresses. Entry i is at bits [8i+7:8i]; entry 0 is 8'h43.
- `CMD_EN`, 1: enables the command transfer.
- `CMD_ADDR` / `CMD_DATA`, 8'hF0 / 8'hF0: command transfer address and data.
- `T_SU`, `T_PW`, `T_HD`, 2 / 4 / 2: setup, strobe and hold cycles per phase. Each is ≥1.
- `IDX_W`, $clog2(N_REGS) (min 1): index width.

Ports:
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: burst request, one-cycle pulse.
- `mode` in 1: 0 = write, 1 = read. Sampled with `start`.
- `busy` out 1: burst in progress.
- `done` out 1: one-cycle pulse at burst end.
- `idx` out IDX_W: current register index.
- `wdata` in 8: register-file data for `idx`.
- `rdata` out 8: captured read data.
- `rvalid` out 1: one-cycle pulse; `rdata`/`idx` valid.
- `ad_out` out 8, `ad_oe` out 1, `ad_in` in 8: AD bus.
- `a_d`, `cs_n`, `rd_n`, `wr_n` out 1 each: RTC control, active-low strobes.

## Operation
- Reset values:
  - `busy`=0, `done`=0, `rvalid`=0, `idx`=0, `rdata`=0.
  - `ad_out`=0, `ad_oe`=0, `a_d`=1, `cs_n`=1, `rd_n`=1, `wr_n`=1.
- States: IDLE, CMD, XFER, DONE. Each transfer has an address phase followed by a data phase.
- IDLE:
  - `start`=1 latches `mode`, sets `idx`=0 and asserts `busy`.
  - Next state is CMD if `CMD_EN` and read mode; otherwise XFER.
- XFER:
  - Runs transfer `idx`.
  - If `idx`=N_REGS−1: goes to CMD when `CMD_EN` and write mode, otherwise to DONE.
  - Otherwise increments `idx`.
- CMD:
  - Write transfer of `CMD_ADDR`/`CMD_DATA`.
  - Then goes to XFER in read mode, or to DONE in write mode.
- DONE: lasts one cycle with `done`=1 and `busy`=0, then returns to IDLE.
- Phase sequencing:
  - `a_d`=0 for the address phase and 1 for the data phase.
  - SETUP: T_SU cycles, strobes high.
  - STROBE: T_PW cycles with `cs_n`=0, plus `wr_n`=0 (write or address) or `rd_n`=0 (read data).
  - HOLD: T_HD cycles, strobes high.
- Bus drive:
  - `ad_oe`=1 in every phase except read data phases.
  - `ad_out` holds the address, or holds `wdata`/`CMD_DATA` registered at the first SETUP cycle of the data phase.
  - `wdata` must be stable while `idx` is stable.
- Read capture:
  - `ad_in` is sampled at the last STROBE cycle into `rdata`.
  - `rvalid` pulses the following cycle with `idx` unchanged.
- `start` while `busy`=1 is ignored. `start` during the DONE cycle is accepted.
- Reset mid-burst: all outputs return to reset values immediately and no `done` is produced.

## Timing
- Phase length: P = T_SU+T_PW+T_HD. Transfer length: 2P.
- Burst length: B = 2P·(N_REGS+CMD_EN). Defaults: P=8, B=160.
- `start` sampled at edge k:
  - `busy`=1 and the first SETUP are visible after edge k.
  - DONE is visible after edge k+B; `busy` falls at the same edge.
- `idx` changes only at transfer boundaries.
- `rvalid` lags the strobe-release edge by 0 cycles: it is asserted in the first HOLD cycle.
- No idle cycles between consecutive phases or transfers.

## Structure
- Package `rtc_pkg`:
  - RTC address constants (seconds/minutes/hours/day/month/year, timer, CMD 8'hF0).
  - Default T_SU/T_PW/T_HD.
  - State enum.
- Sub-module `rtc_bus_phase`: one phase (SETUP/STROBE/HOLD counter).
  - Inputs: `go`, `is_data`, `is_read`, `dout`.
  - Outputs: pins, `cap_data`, `cap_pulse`, `phase_done`.
  - Instantiated once; the top FSM chains phases.

## Test plan
- Write burst with defaults, `wdata`=8'h10+idx:
  - 10 transfers: address pattern 43,42,41,26,25,24,23,22,21,F0 with data 10..18 then F0.
  - `wr_n` low exactly 4 cycles per phase.
  - `done` at k+160.
- Read burst, bench RTC returns addr^8'hFF:
  - First transfer is F0/F0 write.
  - 9 `rvalid` pulses, e.g. idx 0 → `rdata`=8'hBC.
  - `ad_oe`=0 during every read data phase.
- CMD_EN=0, N_REGS=3, T_SU=T_PW=T_HD=1: `done` at k+18; no F0 transfer.
- `start` pulsed mid-burst: ignored, burst length unchanged. `start` in the DONE cycle: new burst begins the next cycle.
- Reset asserted during STROBE of transfer 4: strobes high and `busy`=0 immediately; no `done`. The next `start` restarts at idx 0.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared constants for the RTC parallel-bus burst sequencer: register map, default phase timing, state type.
// No logic; latency and backpressure are properties of the modules that import it.
package rtc_pkg;

    localparam logic [7:0] RTC_A_SEC   = 8'h21;
    localparam logic [7:0] RTC_A_MIN   = 8'h22;
    localparam logic [7:0] RTC_A_HOUR  = 8'h23;
    localparam logic [7:0] RTC_A_DAY   = 8'h24;
    localparam logic [7:0] RTC_A_MONTH = 8'h25;
    localparam logic [7:0] RTC_A_YEAR  = 8'h26;
    localparam logic [7:0] RTC_A_TMR0  = 8'h41;
    localparam logic [7:0] RTC_A_TMR1  = 8'h42;
    localparam logic [7:0] RTC_A_TMR2  = 8'h43;
    localparam logic [7:0] RTC_A_CMD   = 8'hF0;
    localparam logic [7:0] RTC_D_CMD   = 8'hF0;

    localparam int RTC_T_SU   = 2;
    localparam int RTC_T_PW   = 4;
    localparam int RTC_T_HD   = 2;
    localparam int RTC_N_REGS = 9;

    // Entry 0 sits in the low byte, so the burst walks this list right to left.
    localparam logic [8*RTC_N_REGS-1:0] RTC_ADDR_LIST = {
        RTC_A_SEC, RTC_A_MIN, RTC_A_HOUR, RTC_A_DAY, RTC_A_MONTH,
        RTC_A_YEAR, RTC_A_TMR0, RTC_A_TMR1, RTC_A_TMR2
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_XFER,
        ST_DONE
    } seq_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rtc_bus_phase.sv
// One bus phase (SETUP/STROBE/HOLD) of T_SU+T_PW+T_HD cycles, restarting back to back while go stays high.
// Pins follow the phase counter combinationally; read data is captured at the last STROBE cycle, pulse one cycle later.
module rtc_bus_phase
    import rtc_pkg::*;
#(
    parameter int T_SU = RTC_T_SU,
    parameter int T_PW = RTC_T_PW,
    parameter int T_HD = RTC_T_HD
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    input  logic       is_data,
    input  logic       is_read,
    input  logic [7:0] dout,
    input  logic [7:0] ad_in,
    output logic       a_d,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic [7:0] cap_data,
    output logic       cap_pulse,
    output logic       phase_done
);

    localparam int P  = T_SU + T_PW + T_HD;
    localparam int CW = (P > 1) ? $clog2(P) : 1;
    localparam logic [CW-1:0] STB_FIRST = CW'(T_SU);
    localparam logic [CW-1:0] STB_LAST  = CW'(T_SU + T_PW - 1);
    localparam logic [CW-1:0] PH_LAST   = CW'(P - 1);

    logic [CW-1:0] cnt;
    logic [7:0]    dout_q;
    logic          strobe;
    logic          rd_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            dout_q    <= '0;
            cap_data  <= '0;
            cap_pulse <= 1'b0;
        end else begin
            cap_pulse <= 1'b0;
            if (go) begin
                cnt <= (cnt == PH_LAST) ? '0 : cnt + CW'(1);
                if (cnt == '0) begin
                    dout_q <= dout;
                end
                if (rd_data && cnt == STB_LAST) begin
                    cap_data  <= ad_in;
                    cap_pulse <= 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    // The first SETUP cycle passes dout straight through so the bus is valid for the whole phase.
    always_comb begin
        rd_data    = is_data && is_read;
        strobe     = go && (cnt >= STB_FIRST) && (cnt <= STB_LAST);
        cs_n       = ~strobe;
        wr_n       = ~(strobe && !rd_data);
        rd_n       = ~(strobe && rd_data);
        a_d        = go ? is_data : 1'b1;
        ad_oe      = go && !rd_data;
        ad_out     = !go ? 8'h00 : ((cnt == '0) ? dout : dout_q);
        phase_done = go && (cnt == PH_LAST);
    end

endmodule

// File: rtl/rtc_burst_seq.sv
// Burst sequencer: one start pulse runs N_REGS register transfers plus an optional command transfer on the RTC bus.
// Burst takes 2*P*(N_REGS+CMD_EN) cycles after start; start is ignored while busy and accepted in the DONE cycle.
module rtc_burst_seq
    import rtc_pkg::*;
#(
    parameter int                  N_REGS    = RTC_N_REGS,
    parameter logic [8*N_REGS-1:0] ADDR_LIST = RTC_ADDR_LIST,
    parameter bit                  CMD_EN    = 1'b1,
    parameter logic [7:0]          CMD_ADDR  = RTC_A_CMD,
    parameter logic [7:0]          CMD_DATA  = RTC_D_CMD,
    parameter int                  T_SU      = RTC_T_SU,
    parameter int                  T_PW      = RTC_T_PW,
    parameter int                  T_HD      = RTC_T_HD,
    parameter int                  IDX_W     = idx_width(N_REGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] idx,
    input  logic [7:0]       wdata,
    output logic [7:0]       rdata,
    output logic             rvalid,
    output logic [7:0]       ad_out,
    output logic             ad_oe,
    input  logic [7:0]       ad_in,
    output logic             a_d,
    output logic             cs_n,
    output logic             rd_n,
    output logic             wr_n
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REGS - 1);

    seq_state_t       state, state_nx;
    logic [IDX_W-1:0] idx_nx;
    logic             mode_q, mode_nx;
    logic             data_ph, data_ph_nx;
    logic             go;
    logic             is_read;
    logic             phase_done;
    logic [7:0]       addr_sel;
    logic [7:0]       dout;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            idx     <= '0;
            mode_q  <= 1'b0;
            data_ph <= 1'b0;
        end else begin
            state   <= state_nx;
            idx     <= idx_nx;
            mode_q  <= mode_nx;
            data_ph <= data_ph_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        idx_nx     = idx;
        mode_nx    = mode_q;
        data_ph_nx = data_ph;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    mode_nx    = mode;
                    idx_nx     = '0;
                    data_ph_nx = 1'b0;
                    state_nx   = (CMD_EN && mode) ? ST_CMD : ST_XFER;
                end else if (state == ST_DONE) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_CMD: begin
                if (phase_done) begin
                    data_ph_nx = ~data_ph;
                    if (data_ph) begin
                        state_nx = mode_q ? ST_XFER : ST_DONE;
                    end
                end
            end
            ST_XFER: begin
                // A transfer ends when its data phase completes; idx only moves here.
                if (phase_done) begin
                    data_ph_nx = ~data_ph;
                    if (data_ph) begin
                        if (idx == IDX_LAST) begin
                            state_nx = (CMD_EN && !mode_q) ? ST_CMD : ST_DONE;
                        end else begin
                            idx_nx = idx + IDX_W'(1);
                        end
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        go       = (state == ST_CMD) || (state == ST_XFER);
        busy     = go;
        done     = (state == ST_DONE);
        is_read  = mode_q && (state == ST_XFER);
        addr_sel = ADDR_LIST[{idx, 3'b000} +: 8];
        if (state == ST_CMD) begin
            dout = data_ph ? CMD_DATA : CMD_ADDR;
        end else begin
            dout = data_ph ? wdata : addr_sel;
        end
    end

    rtc_bus_phase #(
        .T_SU (T_SU),
        .T_PW (T_PW),
        .T_HD (T_HD)
    ) u_phase (
        .clk        (clk),
        .reset      (reset),
        .go         (go),
        .is_data    (data_ph),
        .is_read    (is_read),
        .dout       (dout),
        .ad_in      (ad_in),
        .a_d        (a_d),
        .cs_n       (cs_n),
        .rd_n       (rd_n),
        .wr_n       (wr_n),
        .ad_out     (ad_out),
        .ad_oe      (ad_oe),
        .cap_data   (rdata),
        .cap_pulse  (rvalid),
        .phase_done (phase_done)
    );

endmodule

// File: tb/tb_rtc_burst_seq.sv
// Bench for rtc_burst_seq: default instance plus a small CMD-less instance with unit phase timing.
// Expected pin traces are computed per cycle from burst offset arithmetic against a simple RTC bus model.
module tb_rtc_burst_seq;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic [7:0] idx;
        logic [7:0] rdata;
        logic       rvalid;
        logic [7:0] ad_out;
        logic       ad_oe;
        logic       a_d;
        logic       cs_n;
        logic       rd_n;
        logic       wr_n;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset0, start0, mode0, busy0, done0, rvalid0, ad_oe0, a_d0, cs_n0, rd_n0, wr_n0;
    logic [3:0] idx0;
    logic [7:0] wdata0, rdata0, ad_out0, ad_in0, rtc_a0;
    logic       reset1, start1, mode1, busy1, done1, rvalid1, ad_oe1, a_d1, cs_n1, rd_n1, wr_n1;
    logic [1:0] idx1;
    logic [7:0] wdata1, rdata1, ad_out1, ad_in1, rtc_a1;

    logic [7:0] wtab [32];
    logic [7:0] key;
    obs_t       obs0, obs1;
    int         compared;
    int         mismatched;

    rtc_burst_seq dut0 (
        .clk(clk), .reset(reset0), .start(start0), .mode(mode0), .busy(busy0), .done(done0),
        .idx(idx0), .wdata(wdata0), .rdata(rdata0), .rvalid(rvalid0), .ad_out(ad_out0),
        .ad_oe(ad_oe0), .ad_in(ad_in0), .a_d(a_d0), .cs_n(cs_n0), .rd_n(rd_n0), .wr_n(wr_n0)
    );

    rtc_burst_seq #(
        .N_REGS(3), .ADDR_LIST(24'h12_34_56), .CMD_EN(1'b0), .T_SU(1), .T_PW(1), .T_HD(1)
    ) dut1 (
        .clk(clk), .reset(reset1), .start(start1), .mode(mode1), .busy(busy1), .done(done1),
        .idx(idx1), .wdata(wdata1), .rdata(rdata1), .rvalid(rvalid1), .ad_out(ad_out1),
        .ad_oe(ad_oe1), .ad_in(ad_in1), .a_d(a_d1), .cs_n(cs_n1), .rd_n(rd_n1), .wr_n(wr_n1)
    );

    // Register file and RTC: the RTC latches the address on an address-phase write strobe.
    assign wdata0 = wtab[{1'b0, idx0}];
    assign wdata1 = wtab[{3'b000, idx1}];
    always @(posedge clk) if (!cs_n0 && !wr_n0 && !a_d0) rtc_a0 <= ad_out0;
    always @(posedge clk) if (!cs_n1 && !wr_n1 && !a_d1) rtc_a1 <= ad_out1;
    assign ad_in0 = rtc_a0 ^ key;
    assign ad_in1 = rtc_a1 ^ key;

    always_comb begin
        obs0 = '{busy0, done0, {4'b0, idx0}, rdata0, rvalid0, ad_out0, ad_oe0, a_d0, cs_n0, rd_n0, wr_n0};
        obs1 = '{busy1, done1, {6'b0, idx1}, rdata1, rvalid1, ad_out1, ad_oe1, a_d1, cs_n1, rd_n1, wr_n1};
    end

    function automatic obs_t get_obs(input int d);
        return (d == 0) ? obs0 : obs1;
    endfunction

    function automatic logic [7:0] addr_of(input int d, input int i);
        if (d == 1) begin
            case (i)
                0:       return 8'h56;
                1:       return 8'h34;
                default: return 8'h12;
            endcase
        end
        case (i)
            0:       return 8'h43;
            1:       return 8'h42;
            2:       return 8'h41;
            3:       return 8'h26;
            4:       return 8'h25;
            5:       return 8'h24;
            6:       return 8'h23;
            7:       return 8'h22;
            default: return 8'h21;
        endcase
    endfunction

    task automatic chk(input string tag, input int t, input logic [7:0] got, input logic [7:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s @%0d: observed %0h expected %0h", tag, t, got, exp);
        end
    endtask

    task automatic drive(input int d, input logic s, input logic m);
        if (d == 0) begin
            start0 = s;
            mode0  = m;
        end else begin
            start1 = s;
            mode1  = m;
        end
    endtask

    task automatic check_reset(input int d);
        obs_t o;
        o = get_obs(d);
        chk("rst_busy", d, 8'(o.busy), 8'd0);
        chk("rst_done", d, 8'(o.done), 8'd0);
        chk("rst_rvalid", d, 8'(o.rvalid), 8'd0);
        chk("rst_idx", d, o.idx, 8'd0);
        chk("rst_rdata", d, o.rdata, 8'd0);
        chk("rst_ad_out", d, o.ad_out, 8'd0);
        chk("rst_ad_oe", d, 8'(o.ad_oe), 8'd0);
        chk("rst_a_d", d, 8'(o.a_d), 8'd1);
        chk("rst_cs_n", d, 8'(o.cs_n), 8'd1);
        chk("rst_rd_n", d, 8'(o.rd_n), 8'd1);
        chk("rst_wr_n", d, 8'(o.wr_n), 8'd1);
    endtask

    // Caller has just raised start at a negedge; offset 0 is the cycle after the sampling edge.
    task automatic check_burst(input int d, input logic m, input int mid_at, input int stop_at,
                               input bit chain, input logic chain_mode);
        int n, ce, tsu, tpw, thd, p, b, j, ph, pos, xi, nrv;
        bit is_cmd, rd, stb, rdph, rv;
        logic [7:0] addr, dat;
        obs_t o;
        n   = (d == 0) ? 9 : 3;
        ce  = (d == 0) ? 1 : 0;
        tsu = (d == 0) ? 2 : 1;
        tpw = (d == 0) ? 4 : 1;
        thd = (d == 0) ? 2 : 1;
        p   = tsu + tpw + thd;
        b   = 2 * p * (n + ce);
        nrv = 0;
        @(negedge clk);
        for (int t = 0; t <= b; t++) begin
            o = get_obs(d);
            if (o.rvalid) nrv++;
            if (t < b) begin
                j   = t / (2 * p);
                ph  = (t % (2 * p)) / p;
                pos = t % p;
                if (!m) begin
                    is_cmd = (j == n);
                    xi     = is_cmd ? n - 1 : j;
                end else begin
                    is_cmd = (ce == 1 && j == 0);
                    xi     = is_cmd ? 0 : j - ce;
                end
                rd   = m && !is_cmd;
                addr = is_cmd ? 8'hF0 : addr_of(d, xi);
                dat  = is_cmd ? 8'hF0 : wtab[xi[4:0]];
                stb  = (pos >= tsu) && (pos < tsu + tpw);
                rdph = rd && (ph == 1);
                rv   = rdph && (pos == tsu + tpw);
                chk("busy", t, 8'(o.busy), 8'd1);
                chk("done", t, 8'(o.done), 8'd0);
                chk("idx", t, o.idx, 8'(xi));
                chk("a_d", t, 8'(o.a_d), 8'(ph));
                chk("cs_n", t, 8'(o.cs_n), 8'(!stb));
                chk("wr_n", t, 8'(o.wr_n), 8'(!(stb && !rdph)));
                chk("rd_n", t, 8'(o.rd_n), 8'(!(stb && rdph)));
                chk("ad_oe", t, 8'(o.ad_oe), 8'(!rdph));
                chk("rvalid", t, 8'(o.rvalid), 8'(rv));
                if (!rdph) chk("ad_out", t, o.ad_out, (ph == 1) ? dat : addr);
                if (rv) chk("rdata", t, o.rdata, addr ^ key);
            end else begin
                chk("end_busy", t, 8'(o.busy), 8'd0);
                chk("end_done", t, 8'(o.done), 8'd1);
                chk("end_cs_n", t, 8'(o.cs_n), 8'd1);
                chk("end_wr_n", t, 8'(o.wr_n), 8'd1);
                chk("end_rd_n", t, 8'(o.rd_n), 8'd1);
                chk("end_ad_oe", t, 8'(o.ad_oe), 8'd0);
                chk("end_rvalid", t, 8'(o.rvalid), 8'd0);
            end
            if (t == stop_at) begin
                drive(d, 1'b0, m);
                return;
            end
            if (t == b) drive(d, chain, chain ? chain_mode : m);
            else if (t == mid_at) drive(d, 1'b1, ~m);
            else drive(d, 1'b0, 1'($urandom));
            if (t < b) @(negedge clk);
        end
        chk("rvalid_count", b, 8'(nrv), m ? 8'(n) : 8'd0);
        if (!chain) begin
            @(negedge clk);
            o = get_obs(d);
            chk("idle_busy", b + 1, 8'(o.busy), 8'd0);
            chk("idle_done", b + 1, 8'(o.done), 8'd0);
        end
    endtask

    task automatic rand_tables();
        for (int i = 0; i < 32; i++) wtab[i] = 8'($urandom);
        key = 8'($urandom);
    endtask

    initial begin
        obs_t o;
        logic m;
        compared   = 0;
        mismatched = 0;
        reset0 = 1'b1; reset1 = 1'b1;
        start0 = 1'b0; start1 = 1'b0;
        mode0  = 1'b0; mode1  = 1'b0;
        key    = 8'hFF;
        for (int i = 0; i < 32; i++) wtab[i] = 8'h10 + 8'(i);
        repeat (3) @(negedge clk);
        check_reset(0);
        check_reset(1);
        reset0 = 1'b0; reset1 = 1'b0;
        repeat (2) @(negedge clk);

        // Default write burst, wdata = 10+idx, with a stray start mid-burst.
        drive(0, 1'b1, 1'b0);
        check_burst(0, 1'b0, 37, -1, 1'b0, 1'b0);

        // Read burst with RTC returning addr^FF; next burst requested in the DONE cycle.
        key = 8'hFF;
        drive(0, 1'b1, 1'b1);
        check_burst(0, 1'b1, 90, -1, 1'b1, 1'b0);
        for (int i = 0; i < 32; i++) wtab[i] = 8'($urandom);
        check_burst(0, 1'b0, -1, -1, 1'b0, 1'b0);

        // Reset during the address STROBE of transfer 4.
        rand_tables();
        drive(0, 1'b1, 1'b0);
        check_burst(0, 1'b0, -1, 4 * 16 + 2, 1'b0, 1'b0);
        reset0 = 1'b1;
        #1;
        check_reset(0);
        repeat (3) @(negedge clk);
        reset0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            o = get_obs(0);
            chk("post_rst_done", i, 8'(o.done), 8'd0);
            chk("post_rst_busy", i, 8'(o.busy), 8'd0);
        end
        drive(0, 1'b1, 1'b0);
        check_burst(0, 1'b0, -1, -1, 1'b0, 1'b0);

        for (int r = 0; r < 4; r++) begin
            rand_tables();
            m = 1'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            drive(0, 1'b1, m);
            check_burst(0, m, int'($urandom_range(1, 150)), -1, 1'b0, 1'b0);
        end

        // Small instance: no command transfer, unit phase timing.
        rand_tables();
        drive(1, 1'b1, 1'b0);
        check_burst(1, 1'b0, 5, -1, 1'b0, 1'b0);
        drive(1, 1'b1, 1'b1);
        check_burst(1, 1'b1, -1, -1, 1'b1, 1'b1);
        key = 8'($urandom);
        check_burst(1, 1'b1, 9, -1, 1'b0, 1'b0);
        for (int r = 0; r < 3; r++) begin
            rand_tables();
            m = 1'($urandom);
            drive(1, 1'b1, m);
            check_burst(1, m, int'($urandom_range(1, 16)), -1, 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
